// File: rtl/seq_pkg.sv
// Shared types for the ALU sequencer: opcodes, FSM states, ALU control codes.
package seq_pkg;

  typedef enum logic [3:0] {
    OP_LDI  = 4'h0,
    OP_INC  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SHL  = 4'h3,
    OP_SUB  = 4'h4,
    OP_SHR  = 4'h5,
    OP_CLR  = 4'h6,
    OP_DEC  = 4'h7,
    OP_JMP  = 4'h8,
    OP_JZ   = 4'h9,
    OP_JN   = 4'hA,
    OP_JC   = 4'hB,
    OP_OUT  = 4'hC,
    OP_NOP1 = 4'hD,
    OP_HALT = 4'hE,
    OP_NOP2 = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    JC_ALWAYS = 2'd0,
    JC_Z      = 2'd1,
    JC_N      = 2'd2,
    JC_C      = 2'd3
  } jump_cond_t;

  typedef struct packed {
    logic s1;
    logic s0;
    logic cin;
  } alu_ctrl_t;

  localparam logic [3:0] OP_ALU_MAX = 4'h7;

endpackage

// File: rtl/alu_sequencer_if.sv
// Bus between the sequencer and its environment: program ROM, 4-bit ALU, output port.
// out_valid is a one-cycle pulse qualifying out_data; there is no ready, the consumer must take it.
interface alu_sequencer_if
  import seq_pkg::*;
  ();
  logic       start;
  logic [3:0] instr_addr;
  logic [7:0] instr_data;
  logic       alu_s0;
  logic       alu_s1;
  logic       alu_cin;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_g;
  logic       alu_cout;
  logic       alu_z;
  logic       alu_n;
  logic [3:0] out_data;
  logic       out_valid;
  logic       halted;
  state_t     dbg_state;

  modport master (
    input  start, instr_data, alu_g, alu_cout, alu_z, alu_n,
    output instr_addr, alu_s0, alu_s1, alu_cin, alu_a, alu_b,
           out_data, out_valid, halted, dbg_state
  );

  modport slave (
    output start, instr_data, alu_g, alu_cout, alu_z, alu_n,
    input  instr_addr, alu_s0, alu_s1, alu_cin, alu_a, alu_b,
           out_data, out_valid, halted, dbg_state
  );
endinterface

// File: rtl/op_decode.sv
// Combinational opcode decoder: ALU select/carry-in code plus jump classification.
module op_decode
  import seq_pkg::*;
(
  input  logic [3:0] op_i,
  output alu_ctrl_t  ctrl_o,
  output logic       is_alu_o,
  output logic       is_jump_o,
  output jump_cond_t cond_o
);

  always_comb begin
    ctrl_o    = '0;
    is_alu_o  = (op_i <= OP_ALU_MAX);
    is_jump_o = 1'b0;
    cond_o    = JC_ALWAYS;
    case (opcode_t'(op_i))
      OP_LDI: ctrl_o = '{s1: 1'b0, s0: 1'b0, cin: 1'b0};
      OP_INC: ctrl_o = '{s1: 1'b0, s0: 1'b0, cin: 1'b1};
      OP_ADD: ctrl_o = '{s1: 1'b0, s0: 1'b1, cin: 1'b0};
      OP_SHL: ctrl_o = '{s1: 1'b0, s0: 1'b1, cin: 1'b1};
      OP_SUB: ctrl_o = '{s1: 1'b1, s0: 1'b0, cin: 1'b1};
      OP_SHR: ctrl_o = '{s1: 1'b1, s0: 1'b0, cin: 1'b0};
      OP_CLR: ctrl_o = '{s1: 1'b1, s0: 1'b1, cin: 1'b1};
      OP_DEC: ctrl_o = '{s1: 1'b1, s0: 1'b1, cin: 1'b0};
      OP_JMP: begin is_jump_o = 1'b1; cond_o = JC_ALWAYS; end
      OP_JZ:  begin is_jump_o = 1'b1; cond_o = JC_Z;      end
      OP_JN:  begin is_jump_o = 1'b1; cond_o = JC_N;      end
      OP_JC:  begin is_jump_o = 1'b1; cond_o = JC_C;      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE controller driving an external 4-bit ALU from a 16-word ROM.
module alu_sequencer
  import seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  alu_sequencer_if.master   bus
);

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [3:0] acc_q, acc_d;
  logic [2:0] flag_q, flag_d;   // {C, Z, N}
  logic [3:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;

  alu_ctrl_t  ctrl;
  logic       is_alu;
  logic       is_jump;
  jump_cond_t cond;
  logic       taken;

  op_decode u_dec (
    .op_i      (ir_q[7:4]),
    .ctrl_o    (ctrl),
    .is_alu_o  (is_alu),
    .is_jump_o (is_jump),
    .cond_o    (cond)
  );

  always_comb begin
    case (cond)
      JC_Z:    taken = flag_q[1];
      JC_N:    taken = flag_q[0];
      JC_C:    taken = flag_q[2];
      default: taken = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    flag_d      = flag_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = bus.instr_data;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 4'd1;
        if (is_alu) begin
          acc_d  = bus.alu_g;
          flag_d = {bus.alu_cout, bus.alu_z, bus.alu_n};
        end
        if (is_jump && taken) pc_d = ir_q[3:0];
        if (ir_q[7:4] == OP_OUT) begin
          out_data_d  = acc_q;
          out_valid_d = 1'b1;
        end
        // PC stays on the HALT word so the stopped address is visible.
        if (ir_q[7:4] == OP_HALT) begin
          state_d = S_HALT;
          pc_d    = pc_q;
        end
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      acc_q       <= '0;
      flag_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
      flag_q      <= flag_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.instr_addr = pc_q;
  assign bus.alu_a      = acc_q;
  assign bus.alu_b      = ir_q[3:0];
  assign bus.alu_s1     = ctrl.s1;
  assign bus.alu_s0     = ctrl.s0;
  assign bus.alu_cin    = ctrl.cin;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.halted     = (state_q == S_HALT);
  assign bus.dbg_state  = state_q;

endmodule
